// File: rtl/prescaler_multi.sv
// rtl/prescaler_multi.sv - NCH independent programmable tick generators; PRESCALER_SQ_EN adds sq outputs
module prescaler_multi #(
    parameter int NCH         = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [WIDTH-1:0] wr_div,
    input  logic [NCH-1:0]   mode,
    input  logic [NCH-1:0]   start,
    input  logic [NCH-1:0]   stop,
    input  logic             sync_clr,
    output logic [NCH-1:0]   p_e,
`ifdef PRESCALER_SQ_EN
    output logic [NCH-1:0]   sq,
`endif
    output logic [NCH-1:0]   busy
);

    typedef enum logic {IDLE, RUN} state_t;

    logic wr_ok;
    assign wr_ok = wr && (int'(wr_ch) < NCH);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           state;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] sdiv;
        logic [WIDTH-1:0] last;
        logic             pend;
        logic             tick;
        logic             wr_hit;
        logic             xfer;

        // Divisors 0 and 1 both mean "every enabled cycle".
        assign last   = (div == '0) ? '0 : div - 1'b1;
        assign tick   = (state == RUN) && en && (cnt == last) && !sync_clr;
        assign wr_hit = wr_ok && (wr_ch == CH_W'(i));
        // The shadow divisor only moves at a period boundary, so a running
        // channel never sees a truncated period.
        assign xfer   = pend && (sync_clr || (state == IDLE) ||
                                 (!stop[i] && (start[i] || tick)));

        assign p_e[i]  = tick;
        assign busy[i] = (state == RUN);

        always_ff @(posedge clk) begin
            if (!rst) begin
                state <= IDLE;
                cnt   <= '0;
                div   <= WIDTH'(DEFAULT_DIV);
                sdiv  <= WIDTH'(DEFAULT_DIV);
                pend  <= 1'b0;
            end else begin
                if (xfer) begin
                    div  <= sdiv;
                    pend <= 1'b0;
                end
                if (wr_hit) begin
                    sdiv <= wr_div;
                    pend <= 1'b1;
                end

                if (sync_clr) begin
                    cnt <= '0;
                end else if (stop[i]) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (start[i]) begin
                    state <= RUN;
                    cnt   <= '0;
                end else if (state == IDLE) begin
                    cnt <= '0;
                end else if (tick) begin
                    cnt <= '0;
                    if (mode[i]) begin
                        state <= IDLE;
                    end
                end else if (en) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

`ifdef PRESCALER_SQ_EN
        logic sq_r;

        always_ff @(posedge clk) begin
            if (!rst) begin
                sq_r <= 1'b0;
            end else if (sync_clr || stop[i]) begin
                sq_r <= 1'b0;
            end else if (start[i]) begin
                sq_r <= sq_r;
            end else if (state == IDLE) begin
                sq_r <= 1'b0;
            end else if (tick) begin
                sq_r <= mode[i] ? 1'b0 : ~sq_r;
            end
        end

        assign sq[i] = sq_r;
`endif
    end

endmodule

// File: tb/tb_prescaler_multi.sv
// tb/tb_prescaler_multi.sv - scoreboard bench for prescaler_multi; tick times queued per channel
module tb_prescaler_multi;

    localparam int NCH   = 5;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             wr = 1'b0;
    logic [2:0]       wr_ch = '0;
    logic [WIDTH-1:0] wr_div = '0;
    logic [NCH-1:0]   mode = '0;
    logic [NCH-1:0]   start = '0;
    logic [NCH-1:0]   stop = '0;
    logic             sync_clr = 1'b0;
    logic [NCH-1:0]   p_e;
    logic [NCH-1:0]   busy;
`ifdef PRESCALER_SQ_EN
    logic [NCH-1:0]   sq;
`endif

    prescaler_multi #(
        .NCH(NCH),
        .WIDTH(WIDTH),
        .DEFAULT_DIV(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .wr(wr),
        .wr_ch(wr_ch),
        .wr_div(wr_div),
        .mode(mode),
        .start(start),
        .stop(stop),
        .sync_clr(sync_clr),
        .p_e(p_e),
`ifdef PRESCALER_SQ_EN
        .sq(sq),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_q[NCH][$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic wrdiv(input int ch, input int d);
        wr     = 1'b1;
        wr_ch  = 3'(ch);
        wr_div = WIDTH'(d);
        step(1);
        wr     = 1'b0;
    endtask

    task automatic pulse_start(input logic [NCH-1:0] m);
        start = m;
        step(1);
        start = '0;
    endtask

    task automatic pulse_stop(input logic [NCH-1:0] m);
        stop = m;
        step(1);
        stop = '0;
    endtask

    task automatic push(input int ch, input int t);
        exp_q[ch].push_back(t);
    endtask

    // Every observed tick must match the oldest expected tick time of its channel.
    always @(negedge clk) begin
        if (rst) begin
            if (!en) check("pe_en_low", 32'(p_e), 0);
            for (int ch = 0; ch < NCH; ch++) begin
                if (p_e[ch]) begin
                    if (exp_q[ch].size() == 0)
                        check($sformatf("pe_extra_ch%0d", ch), cyc, 32'hffff_ffff);
                    else
                        check($sformatf("pe_time_ch%0d", ch), cyc, exp_q[ch].pop_front());
                end
            end
        end
    end

    int c;
    int s;
    bit en_pat[6] = '{1, 0, 1, 0, 1, 1};

    initial begin
        step(3);
        check("rst_busy", 32'(busy), 0);
        check("rst_pe", 32'(p_e), 0);
        rst = 1'b1;
        en  = 1'b1;
        step(1);

        // ch0 at default divisor 10
        c = cyc;
        push(0, c + 10); push(0, c + 20); push(0, c + 30);
        pulse_start(5'b00001);
        check("t1_busy", 32'(busy), 32'b00001);
        wait_to(c + 31);
        pulse_stop(5'b00001);
        check("t1_idle", 32'(busy), 0);
        check("t1_left", exp_q[0].size(), 0);

        // ch1 divisor shrinks mid-period at cnt=5
        c = cyc;
        push(1, c + 10); push(1, c + 13); push(1, c + 16);
        pulse_start(5'b00010);
        wait_to(c + 6);
        wrdiv(1, 3);
        wait_to(c + 17);
        pulse_stop(5'b00010);
        check("t2_left", exp_q[1].size(), 0);

        // ch2 one-shot, twice
        wrdiv(2, 4);
        step(1);
        mode[2] = 1'b1;
        c = cyc;
        push(2, c + 4);
        pulse_start(5'b00100);
        wait_to(c + 4);
        check("t3_busy_tick", 32'(busy[2]), 1);
        step(1);
        check("t3_busy_fall", 32'(busy[2]), 0);
        step(2);
        c = cyc;
        push(2, c + 4);
        pulse_start(5'b00100);
        wait_to(c + 8);
        check("t3_busy_end", 32'(busy[2]), 0);
        check("t3_left", exp_q[2].size(), 0);

        // ch0 div=2 with en gapped
        wrdiv(0, 2);
        step(1);
        c = cyc;
        push(0, c + 3); push(0, c + 6);
        pulse_start(5'b00001);
        for (int k = 0; k < 6; k++) begin
            en = en_pat[k];
            step(1);
        end
        en = 1'b1;
        pulse_stop(5'b00001);
        check("t4_left", exp_q[0].size(), 0);

        // ch3 div 0 then 1, then stop+start together
        wrdiv(3, 0);
        step(1);
        c = cyc;
        for (int k = 1; k <= 6; k++) push(3, c + k);
        pulse_start(5'b01000);
        wait_to(c + 2);
        wrdiv(3, 1);
        wait_to(c + 6);
        start = 5'b01000;
        stop  = 5'b01000;
        step(1);
        start = '0;
        stop  = '0;
        check("t5_stop_wins", 32'(busy[3]), 0);
        step(2);
        check("t5_still_idle", 32'(busy), 0);
        check("t5_left", exp_q[3].size(), 0);

        // out-of-range writes must not land anywhere
        wrdiv(5, 2);
        wrdiv(7, 3);
        step(2);
        c = cyc;
        push(4, c + 10);
        pulse_start(5'b10000);
        wait_to(c + 11);
        pulse_stop(5'b10000);
        check("t5_bad_wr_left", exp_q[4].size(), 0);

        // sync_clr with pending divisors on ch1 and ch4
        c = cyc;
        s = c + 8;
        push(0, c + 2); push(0, c + 4); push(0, c + 6); push(0, s + 2); push(0, s + 4);
        push(1, c + 3); push(1, c + 6); push(1, s + 4);
        push(4, s + 5);
        pulse_start(5'b10011);
        wait_to(c + 3);
        wrdiv(4, 5);
        wait_to(c + 7);
        wrdiv(1, 4);
        sync_clr = 1'b1;
        #1;
        check("t6_pe_forced", 32'(p_e), 0);
`ifdef PRESCALER_SQ_EN
        check("t6_sq_before", 32'(sq), 32'b00001);
`endif
        step(1);
        sync_clr = 1'b0;
        check("t6_busy_kept", 32'(busy), 32'b10011);
`ifdef PRESCALER_SQ_EN
        check("t6_sq_cleared", 32'(sq), 0);
        wait_to(s + 3);
        check("t6_sq_toggle", 32'(sq), 32'b00001);
`endif
        wait_to(s + 5);
        pulse_stop(5'b10011);
        check("t6_idle", 32'(busy), 0);
`ifdef PRESCALER_SQ_EN
        check("t6_sq_idle", 32'(sq), 0);
`endif

        step(3);
        for (int ch = 0; ch < NCH; ch++)
            check($sformatf("pe_missing_ch%0d", ch), exp_q[ch].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
